// File: rtl/sat_accum_sched.sv
// sat_accum_sched
// Round-robin scheduler sharing one saturating-add datapath among NCH
// requesters, with one saturating accumulator per channel and a dump
// sequencer that drains (and clears) every accumulator over a valid/ready
// output stream.
//
// Optional feature macro: SAT_ACCUM_SAT_FLAG_EN
//   defined     -> sticky per-channel saturation flags on sat_flags
//   not defined -> sat_flags tied to 0, no flag registers built
module sat_accum_sched #(
    parameter int NCH  = 4,
    parameter int DW   = 8,
    parameter int ACCW = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*DW-1:0]      in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   dump,
    input  logic                   clr_all,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic [ACCW-1:0]        out_data,
    output logic [NCH-1:0]         sat_flags
);

    localparam int CW = $clog2(NCH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DUMP = 1'b1;

    localparam logic [CW-1:0]   LAST_CH = CW'(NCH - 1);
    localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [CW-1:0]   r_idx;
    logic [CW-1:0]   r_last;
    logic [ACCW-1:0] r_acc [NCH];

    logic            r_out_valid;
    logic            r_busy;
    logic [CW-1:0]   r_out_ch;
    logic [ACCW-1:0] r_out_data;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NCH-1:0]  w_grant;
    logic [CW-1:0]   w_gidx;
    logic            w_found;
    logic            w_hs;
    logic            w_accept;

    logic [DW-1:0]   w_sample;
    logic [ACCW-1:0] w_acc_sel;
    logic [ACCW:0]   w_acc_ext;
    logic [ACCW:0]   w_smp_ext;
    logic [ACCW:0]   w_sum;
    logic            w_ovf;
    logic [ACCW-1:0] w_sat;

    logic [0:0]      w_state_nxt;
    logic [CW-1:0]   w_idx_nxt;
    logic [CW-1:0]   w_last_nxt;
    logic [ACCW-1:0] w_acc_nxt [NCH];

    // Round-robin search: first valid channel after r_last, wrapping.
    // Grants are only issued in RUN.
    // NOTE: every signal driven here gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin : grant_search
        int c;
        c       = 0;
        w_grant = '0;
        w_gidx  = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            c = (int'(r_last) + k) % NCH;
            if (!w_found && (r_state == ST_RUN) && in_valid[c]) begin
                w_found = 1'b1;
                w_gidx  = CW'(c);
            end
        end
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign in_ready = w_grant;
    assign w_hs     = w_found;
    assign w_accept = r_out_valid & out_ready;

    // Shared saturating adder: sum formed one bit wider than the
    // accumulator, then clamped when the top two bits disagree.
    assign w_sample  = in_data[int'(w_gidx)*DW +: DW];
    assign w_acc_sel = r_acc[w_gidx];
    assign w_acc_ext = {w_acc_sel[ACCW-1], w_acc_sel};
    assign w_smp_ext = {{(ACCW+1-DW){w_sample[DW-1]}}, w_sample};
    assign w_sum     = w_acc_ext + w_smp_ext;
    assign w_ovf     = w_sum[ACCW] ^ w_sum[ACCW-1];
    assign w_sat     = !w_ovf        ? w_sum[ACCW-1:0] :
                       w_sum[ACCW]   ? ACC_MIN         : ACC_MAX;

    // Next-state logic: clr_all overrides everything; RUN accumulates the
    // granted sample and may enter DUMP; DUMP drains one word per accept.
    always_comb begin : next_state
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        for (int i = 0; i < NCH; i++) begin
            w_acc_nxt[i] = r_acc[i];
        end

        if (clr_all) begin
            // A same-cycle handshake is consumed but its sample discarded.
            for (int i = 0; i < NCH; i++) begin
                w_acc_nxt[i] = '0;
            end
            w_state_nxt = ST_RUN;
            w_idx_nxt   = '0;
        end else if (r_state == ST_RUN) begin
            if (w_hs) begin
                w_acc_nxt[w_gidx] = w_sat;
                w_last_nxt        = w_gidx;
            end
            if (dump) begin
                w_state_nxt = ST_DUMP;
                w_idx_nxt   = '0;
            end
        end else begin
            if (w_accept) begin
                w_acc_nxt[r_idx] = '0;
                if (r_idx == LAST_CH) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + CW'(1);
                end
            end
        end
    end

    // Control registers: FSM state, drain index and round-robin pointer.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_last  <= LAST_CH;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Accumulator bank.
    // NOTE: the bank is a handful of flops, not a RAM, and the block must
    // come out of reset with every accumulator at zero, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= w_acc_nxt[i];
            end
        end
    end

    // Registered drain outputs, loaded from the next-state view so the word
    // for index 0 already includes a sample accepted on the dump cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= (w_state_nxt == ST_DUMP);
            r_busy      <= (w_state_nxt == ST_DUMP);
            r_out_ch    <= w_idx_nxt;
            r_out_data  <= w_acc_nxt[w_idx_nxt];
        end
    end

    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;

`ifdef SAT_ACCUM_SAT_FLAG_EN
    logic [NCH-1:0] r_flags;

    // Sticky saturation flags: set by a clamped accumulate, cleared when
    // that channel's word is drained, by clr_all, or by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (clr_all) begin
            r_flags <= '0;
        end else begin
            if (w_hs && w_ovf) begin
                r_flags[w_gidx] <= 1'b1;
            end
            if (w_accept) begin
                r_flags[r_idx] <= 1'b0;
            end
        end
    end

    assign sat_flags = r_flags;
`else
    assign sat_flags = '0;
`endif

endmodule

// File: doc/sat_accum_sched.md
# sat_accum_sched

Round-robin scheduler that shares one saturating-add datapath among NCH sample requesters, keeping a saturating accumulator per channel. Requesters present signed samples over valid/ready handshakes; one grant is issued per clock, and the granted sample is added into that channel's accumulator with clamping. A dump sequencer drains all accumulators over a valid/ready output stream and clears each one as it is read. The block sits between per-channel DSP producers and a readout/telemetry consumer.

## Interface
- NCH, 4: number of requesters/channels (2..16)
- DW, 8: signed input sample width
- ACCW, 10: signed accumulator width, ACCW ≥ DW
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NCH*DW  packed samples; channel i at [i*DW +: DW]
- in_valid  in  NCH  per-channel sample valid
- in_ready  out  NCH  per-channel grant/ready, one-hot or zero
- dump  in  1  single-cycle request to drain all accumulators
- clr_all  in  1  synchronous clear of all accumulators and flags
- busy  out  1  high while in DUMP
- out_valid  out  1  drain word valid
- out_ready  in  1  drain consumer ready
- out_ch  out  clog2(NCH)  channel index of drain word
- out_data  out  ACCW  accumulator value of drain word
- sat_flags  out  NCH  sticky per-channel saturation flags (see Configuration)

## Operation
- States: RUN, DUMP. Reset → RUN.
- RUN: combinational round-robin grant. Search starts at the channel after `last`, wrapping. in_ready[g] = 1 for the first valid channel found; all other bits are 0.
- Handshake on channel g (in_valid[g] & in_ready[g]):
  - acc[g] ← sat(acc[g] + sext(sample)).
  - The sum is formed at ACCW+1 bits and clamped to [−2^(ACCW−1), 2^(ACCW−1)−1].
  - `last` ← g.
- No valid input: no grant, `last` holds.
- dump in RUN: the same-cycle handshake is still accepted and included in the drain. Next state is DUMP with idx=0.
- DUMP:
  - in_ready = 0. out_valid = 1, out_ch = idx, out_data = acc[idx].
  - On out_valid & out_ready: acc[idx] ← 0, sat_flags[idx] ← 0, idx++.
  - Accepting idx = NCH−1 returns to RUN. `last` is unchanged.
- dump while in DUMP is ignored.
- clr_all has top priority in any state:
  - all acc ← 0, flags ← 0, idx ← 0, state ← RUN.
  - Any same-cycle handshake is discarded (still consumed, because in_ready was high).
- out_valid stalls indefinitely while out_ready = 0. out_ch and out_data are held stable.

## Timing
- Reset values: acc = 0, sat_flags = 0, `last` = NCH−1 (channel 0 has first priority), idx = 0, state RUN, out_valid = 0, busy = 0, in_ready = 0 unless in_valid is asserted.
- Accumulate latency: 1 clock. The updated acc is visible to a subsequent dump one cycle after the handshake.
- Throughput: one accepted sample per clock in aggregate. Under full load each channel gets 1 of every NCH clocks.
- DUMP entry: out_valid rises the clock after dump is sampled. The minimum drain is NCH clocks with out_ready held high.
- out_valid, out_ch, out_data and busy are driven from registers. in_ready is combinational from in_valid, state and `last`.
- Asynchronous reset mid-DUMP aborts the drain: out_valid drops immediately and accumulators clear.

## Configuration
- SAT_ACCUM_SAT_FLAG_EN defined:
  - sat_flags[i] sets on any accumulate into channel i whose unclamped sum was out of range.
  - The flag stays set until that channel is drained, clr_all, or reset.
- Not defined: sat_flags is tied to 0 and no flag registers are built. Accumulation and clamping are unchanged.

## Test plan
- Round-robin fairness: all four in_valid held high for 8 clocks → grant order 0,1,2,3,0,1,2,3. in_ready is one-hot every cycle.
- Positive saturation: ch0 fed +127 ×5, then dump → out_data 511 for ch0. With SAT_ACCUM_SAT_FLAG_EN, sat_flags[0] = 1 before the drain and 0 after.
- Negative saturation: ch1 fed −128 ×5, ch2 fed +3 then −5, then dump → ch1 = −512, ch2 = −2, ch0 = ch3 = 0, emitted in order 0,1,2,3.
- Drain backpressure: out_ready toggling 1,0,0,1,… during dump → each word is held stable while stalled. in_ready is 0 throughout. busy falls after the ch3 acceptance. A second dump returns all zeros.
- Simultaneous events: dump on the same cycle as a ch2 handshake of +10 → the drain shows ch2 = 10. clr_all on the same cycle as a ch3 handshake → ch3 reads 0 on the next drain.
- Reset mid-drain: rst_n low after 2 of 4 words → out_valid = 0 immediately. After release, a dump returns all zeros and the first grant goes to ch0.
